kb_key_tracker: RTL
===================

# kb_key_tracker

Parametrised PS/2 Set-2 key-state tracker for N configurable keys. It consumes the byte stream from the PS/2 receiver (`scan_done_tick`/`scan_code`) and decodes E0 extended prefixes, F0 break prefixes and the E1 Pause sequence. It keeps a held/released state per tracked key and emits one-cycle press and release pulses. It sits between the PS/2 receiver and game/application logic, replacing single-key, single-code tracking.

## Interface
- `N_KEYS`, default 4: number of tracked keys, 1..16.
- `KEY_CODES`, default {9'h023, 9'h01B, 9'h01C, 9'h01D}: packed N_KEYS×9 bits. Entry i sits at bits [9i+8:9i].
  - Bit 8 is the extended flag (E0-prefixed).
  - Bits 7:0 are the make code.
  - Default maps entry 0=W, 1=A, 2=S, 3=D.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous clear of all key state and the decoder.
- `scan_done_tick` in 1: one-cycle strobe; `scan_code` is valid on this cycle.
- `scan_code` in 8: received byte.
- `key_down` out N_KEYS: bit i = 1 while key i is held.
- `press_tick` out N_KEYS: one-cycle pulse on the 0→1 transition of key i.
- `release_tick` out N_KEYS: one-cycle pulse on the 1→0 transition of key i.
- `any_down` out 1: OR of `key_down`, registered.

## Operation
- Decoder FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (inside an E1 sequence).
- IDLE transitions:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → SKIP with skip count 7.
  - Any other byte produces a make event {0, byte}.
- EXT transitions: F0 → EXT_BRK; any other byte produces a make event {1, byte} and returns to IDLE.
- BRK produces a break event {0, byte} → IDLE.
- EXT_BRK produces a break event {1, byte} → IDLE.
- SKIP decrements its count on each tick and returns to IDLE when the count reaches 0. No events are generated, so Pause is never tracked.
- Control bytes 00, AA, FA, FE, FF generate no event in any state and force the decoder to IDLE.
- E0 received in EXT or EXT_BRK, or F0 received in BRK or EXT_BRK, is absorbed and the state is unchanged.
- Event handling: the 9-bit event code is compared against every `KEY_CODES` entry. All matching entries update, so duplicate entries track identically.
- Make on a key with `key_down`=0: set the bit and pulse `press_tick`.
- Make on a key with `key_down`=1 (typematic repeat): no change, no pulse.
- Break on a key with `key_down`=1: clear the bit and pulse `release_tick`.
- Break on a key with `key_down`=0: ignored.
- Events matching no entry are ignored.
- `clear`: `key_down`←0, decoder→IDLE, skip count←0, no `release_tick`. `clear` has priority over a concurrent `scan_done_tick`; that byte is dropped.
- `scan_done_tick` low: FSM and key state hold and the pulses are 0.

## Timing
- Reset values: `key_down`=0, `press_tick`=0, `release_tick`=0, `any_down`=0, FSM=IDLE, skip count=0.
- All outputs are registered.
- Latency: the event-completing byte arrives on a tick in cycle t. `key_down`, the pulses and `any_down` change at the end of cycle t and are visible in cycle t+1.
- Pulses are exactly one cycle wide. Consecutive-cycle ticks each produce independent pulses.
- Reset asserted mid-sequence (e.g. after E0 or F0) abandons the partial sequence. After reset the next byte is decoded from IDLE.
- Skip count is a 3-bit register, with no wrap hazard because it loads at 7 and counts down to 0.

## Structure
- Shared package `kb_pkg`:
  - byte constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1, SC_BAT=8'hAA, SC_ACK=8'hFA, SC_RESEND=8'hFE, SC_ERR0=8'h00, SC_ERR1=8'hFF;
  - PAUSE_SKIP=3'd7;
  - decoder state typedef;
  - 9-bit key-code typedef.
- Sub-module `kb_scan_decoder`:
  - holds the prefix FSM and skip counter;
  - outputs a one-cycle `evt_valid`, `evt_break` and 9-bit `evt_code` combinationally from the current state and byte.
- The top level instantiates the decoder, then N_KEYS comparators and state bits in a generate loop.

## Test plan
- Bytes 1D, then 1D (typematic), then F0 1D (defaults):
  - `key_down[0]` rises one cycle after the first tick;
  - `press_tick[0]` pulses once;
  - the second 1D gives no pulse;
  - F0 1D clears `key_down[0]` and pulses `release_tick[0]` once;
  - `any_down` follows `key_down[0]`.
- With entry 0 = 9'h174: sending 74 alone sets nothing. E0 74 sets `key_down[0]`. E0 F0 74 releases it. F0 74 alone is ignored.
- E1 14 77 E1 F0 14 F0 77, then 1C: no `key_down` change during the Pause bytes. 1C afterwards sets `key_down[1]`.
- Hold 1D and 1C, then E0 followed by AA, then 1B: AA returns the decoder to IDLE with no event, so 1B sets `key_down[2]`. Then assert `clear` together with a tick carrying F0: all `key_down`=0, no `release_tick`, and the F0 is dropped.
- Reset pulse between F0 and 1D while W is held: all outputs read 0. The following 1D is treated as a make and sets `key_down[0]` with a `press_tick[0]` pulse.
- N_KEYS=2 with both entries 9'h01C: 1C sets both bits and pulses both `press_tick` bits in the same cycle.

Source files
------------

// File: rtl/kb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kb_pkg
// Purpose : Shared constants and types for the PS/2 Set-2 key tracker.
//           Provides scan-code byte constants, the Pause skip length,
//           the prefix decoder state encoding and the 9-bit key code type
//           ({extended, make_code}).
// Rev     : 1.0  initial release
// ============================================================================
package kb_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ERR0   = 8'h00;
   localparam logic [7:0] SC_ERR1   = 8'hFF;

   // Bytes remaining in the Pause sequence after the leading E1
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_SKIP    = 3'd4
   } kb_state_e;

   // Bit 8 = E0-extended flag, bits 7:0 = make code
   typedef logic [8:0] kb_code_t;

   // Keyboard/controller status bytes that never belong to a key sequence
   function automatic logic is_ctrl(input logic [7:0] b);
      return (b == SC_ERR0) || (b == SC_BAT) || (b == SC_ACK) ||
             (b == SC_RESEND) || (b == SC_ERR1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/kb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module  : kb_scan_decoder
// Purpose : PS/2 Set-2 prefix decoder. Tracks E0/F0 prefixes and skips the
//           E1 Pause sequence, emitting a one-cycle make/break event on the
//           byte that completes a sequence.
// Ports   : clk, reset (async, active-high), clear (sync)
//           scan_done_tick / scan_code : received byte strobe and data
//           evt_valid / evt_break / evt_code : combinational event output
// Rev     : 1.0  initial release
// ============================================================================
module kb_scan_decoder
   import kb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       scan_done_tick,
   input  logic [7:0] scan_code,
   output logic       evt_valid,
   output logic       evt_break,
   output kb_code_t   evt_code
);

   kb_state_e  state_q, state_d;
   logic [2:0] skip_q,  skip_d;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         skip_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      if (clear) begin
         state_d = ST_IDLE;
         skip_d  = 3'd0;
      end else if (scan_done_tick) begin
         if (is_ctrl(scan_code)) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (scan_code == SC_EXT)        state_d = ST_EXT;
                  else if (scan_code == SC_BRK)   state_d = ST_BRK;
                  else if (scan_code == SC_PAUSE) begin
                     state_d = ST_SKIP;
                     skip_d  = PAUSE_SKIP;
                  end
               end
               ST_EXT: begin
                  if (scan_code == SC_BRK)        state_d = ST_EXT_BRK;
                  else if (scan_code != SC_EXT)   state_d = ST_IDLE;
               end
               ST_BRK: begin
                  if (scan_code != SC_BRK)        state_d = ST_IDLE;
               end
               ST_EXT_BRK: begin
                  if ((scan_code != SC_BRK) && (scan_code != SC_EXT))
                     state_d = ST_IDLE;
               end
               ST_SKIP: begin
                  skip_d = skip_q - 3'd1;
                  if (skip_q <= 3'd1) begin
                     state_d = ST_IDLE;
                     skip_d  = 3'd0;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  skip_d  = 3'd0;
               end
            endcase
         end
      end
   end

   // Event output: raised only on the byte that completes a make/break
   always_comb begin
      evt_valid = 1'b0;
      evt_break = 1'b0;
      evt_code  = {1'b0, scan_code};
      if (scan_done_tick && !clear && !is_ctrl(scan_code)) begin
         case (state_q)
            ST_IDLE: begin
               evt_valid = (scan_code != SC_EXT) && (scan_code != SC_BRK) &&
                           (scan_code != SC_PAUSE);
            end
            ST_EXT: begin
               evt_valid = (scan_code != SC_BRK) && (scan_code != SC_EXT);
               evt_code  = {1'b1, scan_code};
            end
            ST_BRK: begin
               evt_valid = (scan_code != SC_BRK);
               evt_break = 1'b1;
            end
            ST_EXT_BRK: begin
               evt_valid = (scan_code != SC_BRK) && (scan_code != SC_EXT);
               evt_break = 1'b1;
               evt_code  = {1'b1, scan_code};
            end
            default: evt_valid = 1'b0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/kb_key_tracker.sv
`default_nettype none
// ============================================================================
// Module  : kb_key_tracker
// Purpose : Per-key held/released tracker for N_KEYS configurable PS/2
//           Set-2 keys, with registered press/release pulses.
// Ports   : clk, reset (async, active-high), clear (sync)
//           scan_done_tick / scan_code : byte stream from the PS/2 receiver
//           key_down, press_tick, release_tick : per-key state and pulses
//           any_down : OR of key_down
// Rev     : 1.0  initial release
// ============================================================================
module kb_key_tracker
   import kb_pkg::*;
#(
   parameter int                    N_KEYS    = 4,
   parameter logic [9*N_KEYS-1:0]   KEY_CODES = {9'h023, 9'h01B, 9'h01C, 9'h01D}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              scan_done_tick,
   input  logic [7:0]        scan_code,
   output logic [N_KEYS-1:0] key_down,
   output logic [N_KEYS-1:0] press_tick,
   output logic [N_KEYS-1:0] release_tick,
   output logic              any_down
);

   logic     evt_valid;
   logic     evt_break;
   kb_code_t evt_code;

   logic [N_KEYS-1:0] hit;
   logic [N_KEYS-1:0] key_down_q, key_down_d;
   logic [N_KEYS-1:0] press_q,    press_d;
   logic [N_KEYS-1:0] release_q,  release_d;
   logic              any_down_q;

   kb_scan_decoder u_dec (
      .clk            (clk),
      .reset          (reset),
      .clear          (clear),
      .scan_done_tick (scan_done_tick),
      .scan_code      (scan_code),
      .evt_valid      (evt_valid),
      .evt_break      (evt_break),
      .evt_code       (evt_code)
   );

   // Every matching entry updates, so duplicate codes track identically.
   // Typematic makes and breaks of released keys fall out as no-ops.
   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      assign hit[i]        = evt_valid && (evt_code == KEY_CODES[9*i +: 9]);
      assign press_d[i]    = hit[i] && !evt_break && !key_down_q[i];
      assign release_d[i]  = hit[i] &&  evt_break &&  key_down_q[i];
      assign key_down_d[i] = (key_down_q[i] | press_d[i]) & ~release_d[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_down_q <= '0;
         press_q    <= '0;
         release_q  <= '0;
         any_down_q <= 1'b0;
      end else if (clear) begin
         // Clear drops state silently: no release pulses
         key_down_q <= '0;
         press_q    <= '0;
         release_q  <= '0;
         any_down_q <= 1'b0;
      end else begin
         key_down_q <= key_down_d;
         press_q    <= press_d;
         release_q  <= release_d;
         any_down_q <= |key_down_d;
      end
   end

   assign key_down     = key_down_q;
   assign press_tick   = press_q;
   assign release_tick = release_q;
   assign any_down     = any_down_q;

endmodule
`default_nettype wire
